// File: rtl/fir_ctrl_pkg.sv
// Shared types and helpers for the FIR coefficient controller.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    CLEAN   = 2'd0,
    DIRTY   = 2'd1,
    PENDING = 2'd2
  } fir_ctrl_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TAPS       = 128;

  // Index width for a bank of 'taps' coefficients (taps >= 2).
  function automatic int addr_width(input int taps);
    return (taps < 2) ? 1 : $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient storage: write port into shadow, bulk copy to
// active, registered readback from either bank.
module fir_coeff_bank
  import fir_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAPS       = DEF_TAPS,
  parameter int ADDR_WIDTH = addr_width(TAPS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_wr_en,
  input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic                             i_copy,
  input  logic                             i_rd_sel,
  input  logic [ADDR_WIDTH-1:0]            i_rd_addr,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  output logic [TAPS-1:0][DATA_WIDTH-1:0]  o_active
);

  logic [TAPS-1:0][DATA_WIDTH-1:0] r_shadow;
  logic [TAPS-1:0][DATA_WIDTH-1:0] r_active;
  logic [DATA_WIDTH-1:0]           r_rd_data;
  logic                            w_rd_in_range;

  // Copy reads the pre-edge shadow, so a swap and a write never alias;
  // the controller also blocks writes while a swap can happen.
  for (genvar g = 0; g < TAPS; g++) begin : g_tap
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_shadow[g] <= '0;
        r_active[g] <= '0;
      end else begin
        if (i_wr_en && (i_wr_addr == ADDR_WIDTH'(g)))
          r_shadow[g] <= i_wr_data;
        if (i_copy)
          r_active[g] <= r_shadow[g];
      end
    end
  end

  assign w_rd_in_range = (32'(i_rd_addr) < TAPS);

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_rd_data <= '0;
    else if (!w_rd_in_range)
      r_rd_data <= '0;
    else if (i_rd_sel)
      r_rd_data <= r_active[i_rd_addr];
    else
      r_rd_data <= r_shadow[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
  assign o_active  = r_active;

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Coefficient controller: commit FSM, atomic shadow->active swap at swap_ok,
// and a settle counter that masks FIR output until old partial sums drain.
module fir_coeff_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAPS       = DEF_TAPS,
  parameter int ADDR_WIDTH = addr_width(TAPS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   wr_en,
  input  logic [ADDR_WIDTH-1:0]                  wr_addr,
  input  logic signed [DATA_WIDTH-1:0]           wr_data,
  output logic                                   wr_ready,
  input  logic                                   rd_sel,
  input  logic [ADDR_WIDTH-1:0]                  rd_addr,
  output logic signed [DATA_WIDTH-1:0]           rd_data,
  input  logic                                   commit,
  input  logic                                   swap_ok,
  output logic                                   commit_done,
  output logic                                   busy,
  output logic signed [TAPS-1:0][DATA_WIDTH-1:0] coeff,
  output logic                                   fir_valid
);

  localparam logic [ADDR_WIDTH-1:0] SETTLE = ADDR_WIDTH'(TAPS - 1);

  fir_ctrl_state_t           r_state;
  logic                      r_busy;
  logic                      r_wr_ready;
  logic                      r_commit_done;
  logic [ADDR_WIDTH-1:0]     r_cnt;

  logic                      w_wr_acc;
  logic                      w_swap;
  logic [DATA_WIDTH-1:0]     w_rd_data;
  logic [TAPS-1:0][DATA_WIDTH-1:0] w_active;

  assign w_wr_acc = wr_en && r_wr_ready && (32'(wr_addr) < TAPS);
  assign w_swap   = (r_state == PENDING) && swap_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= CLEAN;
      r_busy        <= 1'b0;
      r_wr_ready    <= 1'b1;
      r_commit_done <= 1'b0;
      r_cnt         <= SETTLE;
    end else begin
      r_commit_done <= 1'b0;
      if (r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
      case (r_state)
        CLEAN: begin
          // Nothing to copy: acknowledge straight away.
          if (commit)
            r_commit_done <= 1'b1;
          if (w_wr_acc)
            r_state <= DIRTY;
        end
        DIRTY: begin
          if (commit) begin
            r_state    <= PENDING;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
          end
        end
        PENDING: begin
          if (swap_ok) begin
            r_state       <= CLEAN;
            r_busy        <= 1'b0;
            r_wr_ready    <= 1'b1;
            r_commit_done <= 1'b1;
            r_cnt         <= SETTLE;
          end
        end
        default: begin
          r_state    <= CLEAN;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  fir_coeff_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAPS       (TAPS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_copy    (w_swap),
    .i_rd_sel  (rd_sel),
    .i_rd_addr (rd_addr),
    .o_rd_data (w_rd_data),
    .o_active  (w_active)
  );

  assign wr_ready    = r_wr_ready;
  assign busy        = r_busy;
  assign commit_done = r_commit_done;
  assign fir_valid   = (r_cnt == '0);
  assign rd_data     = w_rd_data;
  assign coeff       = w_active;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl (TAPS=8) with a readback scoreboard.
module tb_fir_coeff_ctrl;
  localparam int DW   = 16;
  localparam int TAPS = 8;
  localparam int AW   = 3;

  logic                    clk = 1'b0;
  logic                    reset, wr_en, rd_sel, commit, swap_ok;
  logic [AW-1:0]           wr_addr, rd_addr;
  logic [DW-1:0]           wr_data;
  logic                    wr_ready, commit_done, busy, fir_valid;
  logic [DW-1:0]           rd_data;
  logic [TAPS-1:0][DW-1:0] coeff;

  logic [DW-1:0] sh_m [TAPS];
  logic [DW-1:0] ac_m [TAPS];
  logic [DW-1:0] rd_q [$];
  int checks = 0;
  int failures = 0;
  int lows;

  always #5 clk = ~clk;

  fir_coeff_ctrl #(.DATA_WIDTH(DW), .TAPS(TAPS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .rd_sel(rd_sel),
    .rd_addr(rd_addr), .rd_data(rd_data), .commit(commit),
    .swap_ok(swap_ok), .commit_done(commit_done), .busy(busy),
    .coeff(coeff), .fir_valid(fir_valid)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TAPS*DW-1:0] exp_coeff();
    logic [TAPS*DW-1:0] r;
    for (int i = 0; i < TAPS; i++) r[i*DW +: DW] = ac_m[i];
    return r;
  endfunction

  task automatic model_swap();
    for (int i = 0; i < TAPS; i++) ac_m[i] = sh_m[i];
  endtask

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) begin
      sh_m[i] = '0;
      ac_m[i] = '0;
    end
  endtask

  // Push expected readback when the request is driven, pop when data appears.
  task automatic rd_check(input string tag, input logic sel, input int addr);
    rd_sel  = sel;
    rd_addr = AW'(addr);
    rd_q.push_back(sel ? ac_m[addr] : sh_m[addr]);
    step();
    chk(tag, 128'(rd_data), 128'(rd_q.pop_front()));
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] data, input logic accepted);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    step();
    wr_en = 1'b0;
    if (accepted) sh_m[addr] = data;
  endtask

  // Count cycles of fir_valid low starting from the current cycle.
  task automatic count_low(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (fir_valid) break;
      n++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_sel = 1'b0; commit = 1'b0; swap_ok = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    model_clear();
    repeat (3) step();
    reset = 1'b0;

    // cycle 0 after reset release
    chk("rst_coeff", 128'(coeff), 128'(exp_coeff()));
    chk("rst_wr_ready", 128'(wr_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(commit_done), 128'(0));
    chk("rst_rd_data", 128'(rd_data), 128'(0));
    chk("rst_valid_c0", 128'(fir_valid), 128'(0));
    for (int k = 1; k <= TAPS; k++) begin
      step();
      chk($sformatf("rst_valid_c%0d", k), 128'(fir_valid), 128'(k >= TAPS - 1));
    end

    // write idx3, commit, hold swap_ok low for 5 cycles
    wr(3, 16'h1234, 1'b1);
    commit = 1'b1; step(); commit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("pend_busy", 128'(busy), 128'(1));
      chk("pend_wr_ready", 128'(wr_ready), 128'(0));
      if (i == 0) wr(2, 16'h7FFF, 1'b0);
      else step();
    end
    swap_ok = 1'b1; step(); swap_ok = 1'b0; model_swap();
    chk("swap1_coeff3", 128'(coeff[3]), 128'(16'h1234));
    chk("swap1_coeff", 128'(coeff), 128'(exp_coeff()));
    chk("swap1_done", 128'(commit_done), 128'(1));
    chk("swap1_busy", 128'(busy), 128'(0));
    count_low(lows);
    chk("swap1_low_cycles", 128'(lows), 128'(TAPS - 1));
    chk("swap1_done_once", 128'(commit_done), 128'(0));

    rd_check("rd_sh_idx2_dropped", 1'b0, 2);
    rd_check("rd_sh_idx3", 1'b0, 3);
    rd_check("rd_ac_idx3", 1'b1, 3);

    // same-cycle write + commit from DIRTY, then second swap 3 cycles into settle
    wr(5, 16'h0055, 1'b1);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h8000; commit = 1'b1;
    step();
    wr_en = 1'b0; commit = 1'b0; sh_m[0] = 16'h8000;
    chk("samecyc_busy", 128'(busy), 128'(1));
    swap_ok = 1'b1; step(); swap_ok = 1'b0; model_swap();
    chk("swap2_coeff0", 128'(coeff[0]), 128'(16'h8000));
    chk("swap2_coeff", 128'(coeff), 128'(exp_coeff()));
    wr(1, 16'h0101, 1'b1);
    commit = 1'b1; step(); commit = 1'b0;
    chk("settle_mid_valid", 128'(fir_valid), 128'(0));
    swap_ok = 1'b1; step(); swap_ok = 1'b0; model_swap();
    chk("swap3_coeff", 128'(coeff), 128'(exp_coeff()));
    count_low(lows);
    chk("swap3_low_cycles", 128'(lows), 128'(TAPS - 1));

    // commit in CLEAN
    commit = 1'b1; step(); commit = 1'b0;
    chk("clean_done", 128'(commit_done), 128'(1));
    chk("clean_busy", 128'(busy), 128'(0));
    chk("clean_coeff", 128'(coeff), 128'(exp_coeff()));
    chk("clean_valid", 128'(fir_valid), 128'(1));
    step();
    chk("clean_done_once", 128'(commit_done), 128'(0));

    // reset while PENDING discards the commit
    wr(4, 16'h4444, 1'b1);
    commit = 1'b1; step(); commit = 1'b0;
    chk("prerst_busy", 128'(busy), 128'(1));
    reset = 1'b1; swap_ok = 1'b1; step();
    reset = 1'b0; swap_ok = 1'b0; model_clear();
    chk("rst2_busy", 128'(busy), 128'(0));
    chk("rst2_done", 128'(commit_done), 128'(0));
    chk("rst2_coeff", 128'(coeff), 128'(exp_coeff()));
    chk("rst2_valid", 128'(fir_valid), 128'(0));
    rd_check("rst2_rd_sh_idx4", 1'b0, 4);
    chk("rst2_done_after", 128'(commit_done), 128'(0));
    rd_check("rst2_rd_ac_idx0", 1'b1, 0);
    commit = 1'b1; step(); commit = 1'b0;
    chk("rst2_commit_done", 128'(commit_done), 128'(1));
    chk("rst2_commit_busy", 128'(busy), 128'(0));
    chk("rst2_commit_coeff", 128'(coeff), 128'(exp_coeff()));
    step();
    chk("rst2_commit_done_once", 128'(commit_done), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
